sram_fifo_ctrl: RTL

Synchronous FIFO controller that wraps the team's simple dual-port SRAM, which has one write port, one read port, a registered read with 1-cycle latency, and no reset on its array. It converts a valid/ready push stream into SRAM writes and schedules SRAM reads into a 2-entry output skid buffer. This hides the read latency and sustains one pop per cycle. It sits between a producer and consumer on one clock, and drives the SRAM's write and read ports directly.

---
 rtl/sram_fifo_ctrl_pkg.sv | 25 ++
 rtl/sram_fifo_ctrl_if.sv | 39 +++
 rtl/sram_fifo_ctrl_skid2.sv | 90 +++++++++
 rtl/sram_fifo_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared types and width helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    // Occupancy of the two-entry output skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } out_state_e;

    function automatic int addrWidthOf(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count of entries resident in the SRAM, 0..depth inclusive.
    function automatic int cntWidthOf(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Total level: SRAM + one in-flight read + two skid entries.
    function automatic int lvlWidthOf(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop streams, level and SRAM port bundle of the FIFO controller.
// master: producer, consumer and SRAM side; slave: the controller.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 64
);
    localparam int ADDR_WIDTH = sram_fifo_pkg::addrWidthOf(RAM_DEPTH);
    localparam int LVL_WIDTH  = sram_fifo_pkg::lvlWidthOf(RAM_DEPTH);

    logic                  I_PushValid;
    logic                  O_PushReady;
    logic [DATA_WIDTH-1:0] I_PushData;

    logic                  O_PopValid;
    logic                  I_PopReady;
    logic [DATA_WIDTH-1:0] O_PopData;

    logic [LVL_WIDTH-1:0]  O_Level;

    logic                  O_RamWrEn;
    logic [ADDR_WIDTH-1:0] O_RamWrAddr;
    logic [DATA_WIDTH-1:0] O_RamWrData;
    logic                  O_RamRdEn;
    logic [ADDR_WIDTH-1:0] O_RamRdAddr;
    logic [DATA_WIDTH-1:0] I_RamRdData;

    modport master (
        output I_PushValid, I_PushData, I_PopReady, I_RamRdData,
        input  O_PushReady, O_PopValid, O_PopData, O_Level,
               O_RamWrEn, O_RamWrAddr, O_RamWrData, O_RamRdEn, O_RamRdAddr
    );

    modport slave (
        input  I_PushValid, I_PushData, I_PopReady, I_RamRdData,
        output O_PushReady, O_PopValid, O_PopData, O_Level,
               O_RamWrEn, O_RamWrAddr, O_RamWrData, O_RamRdEn, O_RamRdAddr
    );

endinterface

// File: rtl/sram_fifo_ctrl_skid2.sv
// Two-entry output buffer fed by SRAM read returns; head is always a register.
//
//  state | meaning
//  ------+-----------------------------------------
//  EMPTY | nothing buffered, O_Valid low
//  ONE   | head_q holds the oldest entry
//  TWO   | head_q oldest, tail_q next
//
// I_Pop must already be qualified with O_Valid by the caller. The read-issue
// rule upstream never delivers an arrival into TWO unless a pop happens too.
module fifo_skid2
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  I_Clk,
    input  logic                  I_Reset,
    input  logic                  I_Arrival,
    input  logic [DATA_WIDTH-1:0] I_Data,
    input  logic                  I_Pop,
    output logic                  O_Valid,
    output logic [DATA_WIDTH-1:0] O_Head,
    output logic [1:0]            O_OutCnt
);

    out_state_e            state_q;
    out_state_e            state_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    // Occupancy state register.
    always_ff @(posedge I_Clk or posedge I_Reset) begin
        if (I_Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy moves up on arrival, down on pop, stays put when both happen.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (I_Arrival) state_d = ONE;
            end
            ONE: begin
                if (I_Arrival && !I_Pop)      state_d = TWO;
                else if (!I_Arrival && I_Pop) state_d = EMPTY;
            end
            TWO: begin
                if (I_Pop && !I_Arrival) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Outputs come straight from registers, never from the arrival path.
    always_comb begin
        O_Valid  = (state_q != EMPTY);
        O_OutCnt = state_q;
        O_Head   = head_q;
    end

    // Entry storage: fill head first, shift tail into head on pop.
    always_ff @(posedge I_Clk or posedge I_Reset) begin
        if (I_Reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (I_Arrival) head_q <= I_Data;
                end
                ONE: begin
                    if (I_Arrival && I_Pop) head_q <= I_Data;
                    else if (I_Arrival)     tail_q <= I_Data;
                end
                TWO: begin
                    if (I_Pop) begin
                        head_q <= tail_q;
                        if (I_Arrival) tail_q <= I_Data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency dual-port SRAM, with a two-entry
// skid buffer on the output so a pop can be served every cycle.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 64
) (
    input  logic            I_Clk,
    input  logic            I_Reset,
    sram_fifo_ctrl_if.slave fifoBus
);

    localparam int ADDR_WIDTH = addrWidthOf(RAM_DEPTH);
    localparam int LVL_WIDTH  = lvlWidthOf(RAM_DEPTH);
    localparam int CNT_WIDTH  = cntWidthOf(RAM_DEPTH);

    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wrPtr_q;
    logic [ADDR_WIDTH-1:0] rdPtr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  rdPend_q;

    logic                  pushReady;
    logic                  pushFire;
    logic                  popValid;
    logic                  popFire;
    logic                  rdEn;
    logic [1:0]            outCnt;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] popHead;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] incPtr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
    endfunction

    // Ready decodes only the SRAM count; it is held low while reset is applied.
    assign pushReady = !I_Reset && (count_q != FULL_CNT);
    assign pushFire  = fifoBus.I_PushValid && pushReady;
    assign popFire   = popValid && fifoBus.I_PopReady;

    // Issue a read only if skid + in-flight, after this cycle's pop, leaves room.
    assign occupancy = {1'b0, outCnt} + {2'b00, rdPend_q};
    assign rdEn      = (count_q != '0) &&
                       ((occupancy <= 3'd1) || ((occupancy == 3'd2) && popFire));

    // Pointers, SRAM-resident count and the one-deep read-pending flag.
    always_ff @(posedge I_Clk or posedge I_Reset) begin
        if (I_Reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            rdPend_q <= 1'b0;
        end else begin
            if (pushFire) wrPtr_q <= incPtr(wrPtr_q);
            if (rdEn)     rdPtr_q <= incPtr(rdPtr_q);
            if (pushFire && !rdEn)      count_q <= count_q + CNT_WIDTH'(1);
            else if (!pushFire && rdEn) count_q <= count_q - CNT_WIDTH'(1);
            rdPend_q <= rdEn;
        end
    end

    fifo_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) uSkid (
        .I_Clk     (I_Clk),
        .I_Reset   (I_Reset),
        .I_Arrival (rdPend_q),
        .I_Data    (fifoBus.I_RamRdData),
        .I_Pop     (popFire),
        .O_Valid   (popValid),
        .O_Head    (popHead),
        .O_OutCnt  (outCnt)
    );

    assign fifoBus.O_PushReady = pushReady;
    assign fifoBus.O_PopValid  = popValid;
    assign fifoBus.O_PopData   = popHead;
    assign fifoBus.O_Level     = LVL_WIDTH'(count_q) + LVL_WIDTH'(rdPend_q) + LVL_WIDTH'(outCnt);

    assign fifoBus.O_RamWrEn   = pushFire;
    assign fifoBus.O_RamWrAddr = wrPtr_q;
    assign fifoBus.O_RamWrData = fifoBus.I_PushData;
    assign fifoBus.O_RamRdEn   = rdEn;
    assign fifoBus.O_RamRdAddr = rdPtr_q;

endmodule
